// File: rtl/imsic_msi_scheduler.sv
// Round-robin scheduler that turns MSI requests into seteipnum_le writes for one AXI-lite master.
// Latency: ready in the grant cycle, start one cycle later, IDLE again one cycle after busy falls.
// Backpressure: grants only in IDLE; requesters hold valid/payload until their one-hot ready pulse.
module imsic_msi_scheduler #(
    parameter int          NR_REQ                = 4,
    parameter int          NR_IMSICS             = 4,
    parameter int          NR_VS_FILES_PER_IMSIC = 1,
    parameter int          NR_SRC                = 30,
    parameter int          AXI_ADDR_WIDTH        = 64,
    parameter int          AXI_DATA_WIDTH        = 64,
    parameter logic [63:0] IMSIC_BASE            = 64'h2800_0000,
    parameter logic [63:0] IMSIC_STRIDE          = 64'h4000,
    localparam int NR_SRC_LEN    = $clog2(NR_SRC),
    localparam int NR_INTP_FILES = 2 + NR_VS_FILES_PER_IMSIC,
    localparam int IMSIC_LEN     = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
    localparam int FILE_LEN      = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1,
    localparam int REQ_LEN       = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NR_REQ-1:0]                    i_req_valid,
    input  logic [NR_REQ-1:0][IMSIC_LEN-1:0]     i_req_imsic,
    input  logic [NR_REQ-1:0][FILE_LEN-1:0]      i_req_file,
    input  logic [NR_REQ-1:0][NR_SRC_LEN-1:0]    i_req_id,
    output logic [NR_REQ-1:0]                    o_req_ready,
    output logic                                 o_wr_start,
    output logic [AXI_ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]            o_wr_data,
    input  logic                                 i_wr_busy,
    output logic                                 o_busy,
    output logic                                 o_err,
    output logic [REQ_LEN-1:0]                   o_err_src
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ACTIVE = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [REQ_LEN-1:0]        rr_ptr_q;
    logic [REQ_LEN-1:0]        src_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic                      rst_hold_q;

    logic                      grant_vld;
    logic [REQ_LEN-1:0]        grant_idx;
    logic [REQ_LEN:0]          rr_sum;
    logic                      can_grant;
    logic                      req_bad;
    logic [IMSIC_LEN-1:0]      sel_imsic;
    logic [FILE_LEN-1:0]       sel_file;
    logic [NR_SRC_LEN-1:0]     sel_id;
    logic [AXI_ADDR_WIDTH-1:0] addr_c;
    logic [AXI_DATA_WIDTH-1:0] data_c;
    logic [REQ_LEN-1:0]        rr_next;

    // Pick the first pending requester at or after rr_ptr, wrapping at NR_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (REQ_LEN+1)'(i);
            if (rr_sum >= (REQ_LEN+1)'(NR_REQ)) begin
                rr_sum = rr_sum - (REQ_LEN+1)'(NR_REQ);
            end
            if (!grant_vld && i_req_valid[rr_sum[REQ_LEN-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = rr_sum[REQ_LEN-1:0];
            end
        end
    end

    assign sel_imsic = i_req_imsic[grant_idx];
    assign sel_file  = i_req_file[grant_idx];
    assign sel_id    = i_req_id[grant_idx];

    // Identity 0 is reserved; out-of-range file/IMSIC would hit a non-existent page.
    assign req_bad = (sel_id == '0)
                  || (32'(sel_id)    >= NR_SRC)
                  || (32'(sel_file)  >= NR_INTP_FILES)
                  || (32'(sel_imsic) >= NR_IMSICS);

    // seteipnum_le sits at offset 0 of each 4 KiB interrupt-file page.
    assign addr_c = AXI_ADDR_WIDTH'(IMSIC_BASE)
                  + AXI_ADDR_WIDTH'(sel_imsic) * AXI_ADDR_WIDTH'(IMSIC_STRIDE)
                  + (AXI_ADDR_WIDTH'(sel_file) << 12);
    assign data_c = AXI_DATA_WIDTH'(sel_id);

    // No grant while reset is asserted or in the first cycle after it releases.
    assign can_grant = (state_q == S_IDLE) && grant_vld && !i_rst && !rst_hold_q;
    assign rr_next   = (grant_idx == REQ_LEN'(NR_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Next-state and per-state pulse outputs.
    always_comb begin
        state_d     = state_q;
        o_req_ready = '0;
        o_wr_start  = 1'b0;
        o_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    o_req_ready[grant_idx] = 1'b1;
                    state_d = req_bad ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_wr_start = 1'b1;
                state_d    = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!i_wr_busy) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                o_err   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One-cycle synchronous release after reset deasserts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_hold_q <= 1'b1;
        end else begin
            rst_hold_q <= 1'b0;
        end
    end

    // Capture pointer and write payload at grant; held through ISSUE/ACTIVE/ERR.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            src_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (can_grant) begin
            rr_ptr_q <= rr_next;
            src_q    <= grant_idx;
            addr_q   <= addr_c;
            data_q   <= data_c;
        end
    end

    assign o_wr_addr = addr_q;
    assign o_wr_data = data_q;
    assign o_err_src = src_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_imsic_msi_scheduler.sv
// Scoreboard bench for imsic_msi_scheduler with a simple write-master busy model.
// Latency: checks ready/start/err cycle positions and held write payload.
// Backpressure: requesters hold valid until their ready pulse is observed.
module tb_imsic_msi_scheduler;

    logic            i_clk;
    logic            i_rst;
    logic [3:0]      i_req_valid;
    logic [3:0][1:0] i_req_imsic;
    logic [3:0][1:0] i_req_file;
    logic [3:0][4:0] i_req_id;
    logic [3:0]      o_req_ready;
    logic            o_wr_start;
    logic [63:0]     o_wr_addr;
    logic [63:0]     o_wr_data;
    logic            i_wr_busy;
    logic            o_busy;
    logic            o_err;
    logic [1:0]      o_err_src;

    imsic_msi_scheduler dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_imsic (i_req_imsic),
        .i_req_file  (i_req_file),
        .i_req_id    (i_req_id),
        .o_req_ready (o_req_ready),
        .o_wr_start  (o_wr_start),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_busy   (i_wr_busy),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_err_src   (o_err_src)
    );

    typedef struct {
        int          src;
        bit          err;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t       sbq[$];
    exp_t       cur;
    int         phase;
    int         total;
    int         bad;
    int         cnt[4];
    logic [3:0] acc;
    int         bcnt;
    int         busy_lo;
    int         busy_hi;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int r, input int im, input int f, input int id);
        exp_t e;
        e.src  = r;
        e.err  = (id == 0) || (id >= 30) || (f >= 3) || (im >= 4);
        e.addr = 64'h2800_0000 + 64'(im) * 64'h4000 + 64'(f) * 64'h1000;
        e.data = 64'(id);
        return e;
    endfunction

    task automatic sync();
        @(posedge i_clk);
        #2;
    endtask

    task automatic post(input int r, input int im, input int f, input int id, input int n);
        i_req_imsic[r] = 2'(im);
        i_req_file[r]  = 2'(f);
        i_req_id[r]    = 5'(id);
        cnt[r]         = n;
        i_req_valid[r] = 1'b1;
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while (k < lim && !(sbq.size() == 0 && phase == 0 && !o_busy &&
                            cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0 && cnt[3] == 0)) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain_left", 64'(sbq.size()), 0);
        @(negedge i_clk);
    endtask

    task automatic wait_phase2();
        int k;
        k = 0;
        while (k < 50 && phase != 2) begin
            @(negedge i_clk);
            k++;
        end
        chk("reach_active", 64'(phase), 2);
    endtask

    // Write master: busy from the cycle after start for busy_lo..busy_hi cycles.
    always @(posedge i_clk) begin
        #1;
        if (i_rst) begin
            bcnt      = 0;
            i_wr_busy = 1'b0;
        end else begin
            i_wr_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
            if (o_wr_start) bcnt = $urandom_range(busy_hi, busy_lo);
        end
    end

    // Requester side: capture accepts, drop valid when a requester has nothing left.
    always @(negedge i_clk) acc = o_req_ready;

    always @(posedge i_clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                cnt[i]--;
                i_req_valid[i] = (cnt[i] > 0);
            end
        end
    end

    // Output monitor: pop expectations on each accept, then check start/err and held payload.
    always @(negedge i_clk) begin
        if (i_rst) begin
            phase = 0;
        end else if (o_req_ready != 4'b0) begin
            chk("rdy_onehot", 64'($onehot(o_req_ready)), 1);
            chk("rdy_master_idle", i_wr_busy, 0);
            if (sbq.size() == 0) begin
                chk("rdy_unexp", o_req_ready, 0);
            end else begin
                cur = sbq.pop_front();
                chk("rdy_src", o_req_ready, 64'(1) << cur.src);
                phase = 1;
            end
        end else if (phase == 1) begin
            chk("start", o_wr_start, !cur.err);
            chk("err", o_err, cur.err);
            if (cur.err) begin
                chk("err_src", o_err_src, 64'(cur.src));
                phase = 0;
            end else begin
                chk("addr", o_wr_addr, cur.addr);
                chk("data", o_wr_data, cur.data);
                phase = 2;
            end
        end else if (phase == 2) begin
            chk("hold_start", o_wr_start, 0);
            chk("hold_addr", o_wr_addr, cur.addr);
            chk("hold_data", o_wr_data, cur.data);
            if (!o_busy) phase = 0;
        end else begin
            chk("idle_start", o_wr_start, 0);
            chk("idle_err", o_err, 0);
        end
    end

    initial begin
        bit seen;
        bit fell;
        total       = 0;
        bad         = 0;
        phase       = 0;
        bcnt        = 0;
        busy_lo     = 2;
        busy_hi     = 4;
        acc         = '0;
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_imsic = '0;
        i_req_file  = '0;
        i_req_id    = '0;
        i_wr_busy   = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;

        #3;
        chk("rst_ready", o_req_ready, 0);
        chk("rst_start", o_wr_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        chk("rst_err_src", o_err_src, 0);
        chk("rst_addr", o_wr_addr, 0);
        chk("rst_data", o_wr_data, 0);
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;

        // Single request: requester 1, imsic 2, file 1, id 5.
        sync();
        post(1, 2, 1, 5, 1);
        sbq.push_back(mk(1, 2, 1, 5));
        @(negedge i_clk);
        chk("t1_ready", o_req_ready, 4'b0010);
        @(negedge i_clk);
        chk("t1_start", o_wr_start, 1);
        chk("t1_addr", o_wr_addr, 64'h2800_9000);
        chk("t1_data", o_wr_data, 64'd5);
        seen = 0;
        fell = 0;
        for (int k = 0; k < 50 && !fell; k++) begin
            @(negedge i_clk);
            if (i_wr_busy) seen = 1;
            else if (seen) fell = 1;
        end
        chk("t1_busy_fell", 64'(fell), 1);
        chk("t1_obusy_hold", o_busy, 1);
        @(negedge i_clk);
        chk("t1_obusy_low", o_busy, 0);
        drain(100);

        // Invalid file on requester 3; leaves rr_ptr at 0.
        sync();
        post(3, 0, 3, 7, 1);
        sbq.push_back(mk(3, 0, 3, 7));
        @(negedge i_clk);
        chk("inv_ready", o_req_ready, 4'b1000);
        @(negedge i_clk);
        chk("inv_err", o_err, 1);
        chk("inv_src", o_err_src, 3);
        chk("inv_nostart", o_wr_start, 0);
        @(negedge i_clk);
        chk("inv_err_once", o_err, 0);
        drain(100);

        // Contention: all four pending with rr_ptr 0, requester 0 twice.
        busy_lo = 1;
        busy_hi = 5;
        sync();
        post(0, 0, 0, 1, 2);
        post(1, 1, 1, 17, 1);
        post(2, 3, 2, 29, 1);
        post(3, 2, 0, 9, 1);
        sbq.push_back(mk(0, 0, 0, 1));
        sbq.push_back(mk(1, 1, 1, 17));
        sbq.push_back(mk(2, 3, 2, 29));
        sbq.push_back(mk(3, 2, 0, 9));
        sbq.push_back(mk(0, 0, 0, 1));
        drain(500);

        // id 0 on requester 2 is rejected; moves rr_ptr to 3.
        sync();
        post(2, 1, 0, 0, 1);
        sbq.push_back(mk(2, 1, 0, 0));
        drain(100);

        // Wrap: rr_ptr 3 with requesters 0 and 3 pending.
        sync();
        post(0, 1, 1, 21, 1);
        post(3, 3, 2, 29, 1);
        sbq.push_back(mk(3, 3, 2, 29));
        sbq.push_back(mk(0, 1, 1, 21));
        drain(200);

        // Stability: inputs change during ACTIVE.
        busy_lo = 6;
        busy_hi = 6;
        sync();
        post(1, 1, 0, 3, 1);
        sbq.push_back(mk(1, 1, 0, 3));
        wait_phase2();
        sync();
        i_req_imsic[1] = 2'd3;
        i_req_file[1]  = 2'd2;
        i_req_id[1]    = 5'd17;
        post(2, 1, 2, 12, 1);
        sbq.push_back(mk(2, 1, 2, 12));
        repeat (3) begin
            @(negedge i_clk);
            chk("stab_no_ready", o_req_ready, 0);
            chk("stab_addr", o_wr_addr, mk(1, 1, 0, 3).addr);
        end
        drain(200);

        // Reset mid-ACTIVE with requesters 0 and 3 held; rr_ptr would be 3 without reset.
        busy_lo = 8;
        busy_hi = 8;
        sync();
        post(2, 0, 1, 4, 1);
        sbq.push_back(mk(2, 0, 1, 4));
        wait_phase2();
        sync();
        post(0, 2, 0, 11, 1);
        post(3, 1, 1, 13, 1);
        sbq.push_back(mk(0, 2, 0, 11));
        sbq.push_back(mk(3, 1, 1, 13));
        sync();
        i_rst = 1'b1;
        #1;
        chk("mid_rst_ready", o_req_ready, 0);
        chk("mid_rst_start", o_wr_start, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_err", o_err, 0);
        chk("mid_rst_err_src", o_err_src, 0);
        chk("mid_rst_addr", o_wr_addr, 0);
        chk("mid_rst_data", o_wr_data, 0);
        sync();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_release_ready", o_req_ready, 0);
        @(negedge i_clk);
        chk("rst_regrant", o_req_ready, 4'b0001);
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
